// File: rtl/seq_addsub_if.sv
// rtl/seq_addsub_if.sv - request/result bundle for the multi-cycle adder/subtractor
interface seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - chunk-serial adder/subtractor with registered carry and committed results
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_addsub_if.slave bus
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // already inverted in subtract mode
  logic              c_q, c_d;       // carry between chunks
  logic [WIDTH-1:0]  acc_q, acc_d;   // partial result, never visible on the outputs
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  int                base;
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK:0]    chunk_res;
  logic [WIDTH-1:0]  acc_new;
  logic              last;

  // One chunk of the ripple: select the current slice, add it with the stored carry, splice it back.
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    chunk_a   = a_q[base +: CHUNK];
    chunk_b   = b_q[base +: CHUNK];
    chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, c_q};
    acc_new   = acc_q;
    acc_new[base +: CHUNK] = chunk_res[CHUNK-1:0];
    last      = (idx_q == IDXW'(NCH - 1));
  end

  // Next-state and datapath control; outputs only move on the final chunk.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ? 1'b1 : bus.carry_in;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_new;
        c_d   = chunk_res[CHUNK];
        idx_d = idx_q + 1'b1;
        if (last) begin
          sum_d   = acc_new;
          cout_d  = chunk_res[CHUNK];
          // Same-sign operands producing an opposite-sign result is signed overflow.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_new[WIDTH-1] != a_q[WIDTH-1]);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - directed vectors, multi-cycle corner cases and width/chunk sweep for seq_addsub
module tb_seq_addsub;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic sweep_go;
  logic [2:0] sw_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(32)) mif ();

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch one operation on the 32-bit instance; returns at the negedge where done is seen.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output int n);
    @(negedge clk);
    mif.start = 1'b1; mif.sub = s; mif.a = a; mif.b = b; mif.carry_in = cin;
    @(negedge clk);
    mif.start = 1'b0;
    n = 0;
    while (!mif.done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl [10];

  // Width/chunk sweep: three 16-bit instances against an a+b'+c0 reference.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int CH  = (g == 0) ? 4 : (g == 1) ? 8 : 16;
    localparam int NCH = 16 / CH;
    seq_addsub_if #(.WIDTH(16)) sif ();
    seq_addsub #(.WIDTH(16), .CHUNK(CH)) dut_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
    );

    initial begin
      logic [15:0] ra, rb, bp;
      logic        rs, rc, c0, rov;
      logic [16:0] rsum;
      int          n;
      sif.start = 1'b0; sif.sub = 1'b0; sif.a = '0; sif.b = '0; sif.carry_in = 1'b0;
      sw_done[g] = 1'b0;
      wait (sweep_go === 1'b1);
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rs = 1'($urandom); rc = 1'($urandom);
        if (i == 0) begin ra = 16'hFFFF; rb = 16'h0001; rs = 1'b0; rc = 1'b1; end
        if (i == 1) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; rc = 1'b0; end
        bp   = rs ? ~rb : rb;
        c0   = rs ? 1'b1 : rc;
        rsum = {1'b0, ra} + {1'b0, bp} + {16'd0, c0};
        rov  = (ra[15] == bp[15]) && (rsum[15] != ra[15]);
        @(negedge clk);
        sif.start = 1'b1; sif.sub = rs; sif.a = ra; sif.b = rb; sif.carry_in = rc;
        @(negedge clk);
        sif.start = 1'b0;
        n = 0;
        while (!sif.done && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("sw%0d_v%0d_latency", CH, i), 64'(n), 64'(NCH));
        chk($sformatf("sw%0d_v%0d_sum", CH, i), 64'(sif.sum), 64'(rsum[15:0]));
        chk($sformatf("sw%0d_v%0d_cout", CH, i), 64'(sif.carry_out), 64'(rsum[16]));
        chk($sformatf("sw%0d_v%0d_ovf", CH, i), 64'(sif.overflow), 64'(rov));
      end
      sw_done[g] = 1'b1;
    end
  end

  initial begin
    int n, m, t;
    logic seen;

    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};

    checks = 0; errors = 0; sweep_go = 1'b0;
    rst_n = 1'b0;
    mif.start = 1'b0; mif.sub = 1'b0; mif.a = '0; mif.b = '0; mif.carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(mif.busy), 64'd0);
    chk("reset_done", 64'(mif.done), 64'd0);
    chk("reset_sum", 64'(mif.sum), 64'd0);
    chk("reset_cout", 64'(mif.carry_out), 64'd0);
    chk("reset_ovf", 64'(mif.overflow), 64'd0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, n);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'd4);
      chk($sformatf("v%0d_sum", i), 64'(mif.sum), 64'(tbl[i].s));
      chk($sformatf("v%0d_cout", i), 64'(mif.carry_out), 64'(tbl[i].co));
      chk($sformatf("v%0d_ovf", i), 64'(mif.overflow), 64'(tbl[i].ov));
      chk($sformatf("v%0d_busy_at_done", i), 64'(mif.busy), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 64'(mif.done), 64'd0);
    end

    // Start while busy is ignored, and the old result holds during the run.
    @(negedge clk);
    mif.start = 1'b1; mif.sub = 1'b0; mif.a = 32'd1; mif.b = 32'd2; mif.carry_in = 1'b0;
    @(negedge clk);
    mif.start = 1'b0; n = 0;
    chk("busy_after_accept", 64'(mif.busy), 64'd1);
    @(negedge clk); n++;
    mif.start = 1'b1; mif.sub = 1'b1; mif.a = 32'd100; mif.b = 32'd200; mif.carry_in = 1'b1;
    @(negedge clk); n++;
    mif.start = 1'b0;
    chk("sum_holds_during_run", 64'(mif.sum), 64'h100);
    while (!mif.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_start_latency", 64'(n), 64'd4);
    chk("busy_start_sum", 64'(mif.sum), 64'd3);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mif.done || mif.busy) seen = 1'b1;
    end
    chk("busy_start_not_queued", 64'(seen), 64'd0);

    // Start during the done cycle is accepted; next done 5 cycles later.
    run_op(1'b0, 32'd10, 32'd20, 1'b0, n);
    chk("b2b_first_latency", 64'(n), 64'd4);
    chk("b2b_first_sum", 64'(mif.sum), 64'd30);
    mif.start = 1'b1; mif.sub = 1'b0; mif.a = 32'd3; mif.b = 32'd4; mif.carry_in = 1'b0;
    @(negedge clk);
    mif.start = 1'b0; m = 1;
    while (!mif.done && m < 20) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_spacing", 64'(m), 64'd5);
    chk("b2b_second_sum", 64'(mif.sum), 64'd7);

    // Reset mid-operation.
    @(negedge clk);
    mif.start = 1'b1; mif.sub = 1'b0; mif.a = 32'd1000; mif.b = 32'd1; mif.carry_in = 1'b0;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 64'(mif.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(mif.busy), 64'd0);
    chk("midrst_done", 64'(mif.done), 64'd0);
    chk("midrst_sum", 64'(mif.sum), 64'd0);
    chk("midrst_cout", 64'(mif.carry_out), 64'd0);
    chk("midrst_ovf", 64'(mif.overflow), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mif.done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mif.done) seen = 1'b1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_op(1'b0, 32'h11111111, 32'h22222222, 1'b0, n);
    chk("post_rst_latency", 64'(n), 64'd4);
    chk("post_rst_sum", 64'(mif.sum), 64'h33333333);

    // Parameter sweep on the 16-bit instances.
    sweep_go = 1'b1;
    t = 0;
    while (sw_done != 3'b111 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_complete", 64'(sw_done), 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
